// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared sizes, loader FSM states and CPU opcode constants.
// Used by: prog_loader, ld_sum8 and the testbench for building programs.
package prog_loader_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RELEASE, RUN, ERROR} state_e;

    localparam logic [3:0] op_nop = 4'h0;
    localparam logic [3:0] op_lda = 4'h1;
    localparam logic [3:0] op_add = 4'h2;
    localparam logic [3:0] op_sub = 4'h3;
    localparam logic [3:0] op_sta = 4'h4;
    localparam logic [3:0] op_ldi = 4'h5;
    localparam logic [3:0] op_jmp = 4'h6;
    localparam logic [3:0] op_jc  = 4'h7;
    localparam logic [3:0] op_jz  = 4'h8;
    localparam logic [3:0] op_out = 4'he;
    localparam logic [3:0] op_hlt = 4'hf;

    function automatic logic [4:0] sat_len(input logic [4:0] l);
        return (l > 5'(DEPTH)) ? 5'(DEPTH) : l;
    endfunction
endpackage

// File: rtl/ld_sum8.sv
// ld_sum8: 8-bit modulo-256 accumulator with synchronous clear and enable.
// Ports: clk, clr (sync reset), clear_i (restart sum), en_i (add data_i),
//        sum_o (current sum), nxt_o (sum_o + data_i, combinational).
module ld_sum8
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] sum_o,
    output logic [DATA_W-1:0] nxt_o
);
    logic [DATA_W-1:0] sum_q, sum_d;

    assign nxt_o = sum_q + data_i;
    assign sum_o = sum_q;

    always_comb sum_d = clear_i ? '0 : en_i ? nxt_o : sum_q;

    always_ff @(posedge clk) begin
        if (clr) sum_q <= '0;
        else     sum_q <= sum_d;
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a program into RAM, verifies it by checksum, then releases the CPU.
// Ports: clk/clr (sync reset); ld_start/ld_len/ld_valid/ld_data/ld_ready byte source;
//        cpu_addr/cpu_we/cpu_wdata CPU RAM port; ram_addr/ram_we/ram_wdata/ram_rdata RAM;
//        cpu_hold/cpu_clr CPU control; busy/err status.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              ld_start,
    input  logic [4:0]        ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_hold,
    output logic              cpu_clr,
    output logic              busy,
    output logic              err
);
    state_e            state_q, state_d;
    logic [4:0]        len_q, len_d, cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d, err_q, err_d;
    logic [DATA_W-1:0] sum_w, sum_r, sum_w_nxt, sum_r_nxt;
    logic              start, acc, run, last_v;

    assign start    = ld_start && (state_q == IDLE || state_q == RUN || state_q == ERROR);
    assign ld_ready = (state_q == LOAD) && (cnt_q != len_q);
    assign acc      = ld_valid && ld_ready;
    assign run      = (state_q == RUN);
    // Final verify read: the checksum decision uses the sum including this read.
    assign last_v   = (state_q == VERIFY) && ({1'b0, ptr_q} == len_q - 5'd1);

    ld_sum8 u_sum_w (
        .clk(clk), .clr(clr), .clear_i(start), .en_i(acc),
        .data_i(ld_data), .sum_o(sum_w), .nxt_o(sum_w_nxt)
    );

    ld_sum8 u_sum_r (
        .clk(clk), .clr(clr), .clear_i(start), .en_i(state_q == VERIFY),
        .data_i(ram_rdata), .sum_o(sum_r), .nxt_o(sum_r_nxt)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        wr_d    = acc;
        waddr_d = acc ? ptr_q : waddr_q;
        wdata_d = acc ? ld_data : wdata_q;
        case (state_q)
            LOAD: begin
                ptr_d = acc ? ptr_q + 1'b1 : ptr_q;
                cnt_d = acc ? cnt_q + 1'b1 : cnt_q;
                // cnt == len only in the cycle of the final write, so VERIFY starts after it.
                if (cnt_q == len_q) begin
                    state_d = VERIFY;
                    ptr_d   = '0;
                end
            end
            VERIFY: begin
                ptr_d = ptr_q + 1'b1;
                if (last_v) begin
                    state_d = (sum_r_nxt == sum_w) ? RELEASE : ERROR;
                    err_d   = (sum_r_nxt != sum_w);
                end
            end
            RELEASE: state_d = RUN;
            default: ;
        endcase
        if (start) begin
            len_d   = sat_len(ld_len);
            cnt_d   = '0;
            ptr_d   = '0;
            err_d   = 1'b0;
            state_d = (sat_len(ld_len) == 5'd0) ? RELEASE : LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // wr_q can only be set by an accept in LOAD, so outside RUN it is the sole write source.
    assign ram_addr  = run ? cpu_addr : (state_q == VERIFY) ? ptr_q : waddr_q;
    assign ram_we    = run ? cpu_we : wr_q;
    assign ram_wdata = run ? cpu_wdata : wdata_q;
    assign cpu_hold  = !run;
    assign cpu_clr   = (state_q == RELEASE);
    assign busy      = (state_q == LOAD) || (state_q == VERIFY) || (state_q == RELEASE);
    assign err       = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader with a behavioural RAM.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ld_start = 1'b0;
    logic [4:0] ld_len = '0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_ready;
    logic [3:0] cpu_addr = '0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_wdata = '0;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       cpu_hold, cpu_clr, busy, err;

    logic [7:0] mem [16];
    logic       force_en = 1'b0;
    logic [3:0] force_addr = 4'h1;
    logic [7:0] force_val = 8'h2E;
    int         we_cnt = 0;
    int         clr_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prog [4];

    always #5 clk = ~clk;

    prog_loader dut (
        .clk(clk), .clr(clr), .ld_start(ld_start), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .cpu_hold(cpu_hold), .cpu_clr(cpu_clr),
        .busy(busy), .err(err)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_we) we_cnt <= we_cnt + 1;
        if (cpu_clr) clr_cnt <= clr_cnt + 1;
    end

    assign ram_rdata = (force_en && ram_addr == force_addr) ? force_val : mem[ram_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [4:0] n);
        ld_len = n;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b, input int gap);
        int n = 0;
        while (!ld_ready && n < 20) begin
            step();
            n++;
        end
        chk("feed_ready", ld_ready, 1);
        ld_valid = 1'b1;
        ld_data = b;
        step();
        ld_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        chk("done_timeout", busy, 0);
    endtask

    task automatic load_prog(input int gap);
        start(5'd4);
        for (int i = 0; i < 4; i++) feed(prog[i], gap);
        wait_idle();
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        cpu_addr = a;
        cpu_wdata = d;
        cpu_we = 1'b1;
        step();
        cpu_we = 1'b0;
    endtask

    task automatic check_prog(input string tag);
        for (int i = 0; i < 4; i++) chk(tag, mem[i], prog[i]);
    endtask

    initial begin
        int w0, c0, n;
        logic [7:0] acc;
        prog[0] = {op_lda, 4'he};
        prog[1] = {op_add, 4'hf};
        prog[2] = {op_out, 4'h0};
        prog[3] = {op_hlt, 4'h0};

        step();
        step();
        chk("rst_hold", cpu_hold, 1);
        chk("rst_cpu_clr", cpu_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_we", ram_we, 0);
        clr = 1'b0;
        step();

        // zero-length load: straight to RELEASE then RUN, no writes
        w0 = we_cnt;
        start(5'd0);
        chk("len0_release_clr", cpu_clr, 1);
        chk("len0_release_hold", cpu_hold, 1);
        chk("len0_release_busy", busy, 1);
        step();
        chk("len0_run_hold", cpu_hold, 0);
        chk("len0_run_clr", cpu_clr, 0);
        chk("len0_we", we_cnt - w0, 0);

        // CPU pass-through in RUN, presets data words
        cpu_addr = 4'he;
        cpu_wdata = 8'h38;
        cpu_we = 1'b1;
        #1;
        chk("pass_addr", ram_addr, 4'he);
        chk("pass_we", ram_we, 1);
        chk("pass_wdata", ram_wdata, 8'h38);
        step();
        cpu_we = 1'b0;
        cpu_write(4'hf, 8'h23);
        chk("preset_e", mem[14], 8'h38);
        chk("preset_f", mem[15], 8'h23);

        // scenario 1: contiguous load
        w0 = we_cnt;
        c0 = clr_cnt;
        load_prog(0);
        check_prog("s1_ram");
        chk("s1_we", we_cnt - w0, 4);
        chk("s1_clr_pulse", clr_cnt - c0, 1);
        chk("s1_hold", cpu_hold, 0);
        chk("s1_err", err, 0);
        acc = mem[mem[0][3:0]] + mem[mem[1][3:0]];
        chk("s1_display", acc, 8'h5B);

        // scenario 2: gapped load into cleared RAM
        for (int i = 0; i < 4; i++) cpu_write(4'(i), 8'h00);
        w0 = we_cnt;
        c0 = clr_cnt;
        load_prog(1);
        check_prog("s2_ram");
        chk("s2_we", we_cnt - w0, 4);
        chk("s2_clr_pulse", clr_cnt - c0, 1);
        chk("s2_hold", cpu_hold, 0);

        // scenario 3: corrupted read-back
        force_en = 1'b1;
        c0 = clr_cnt;
        load_prog(0);
        force_en = 1'b0;
        chk("s3_err", err, 1);
        chk("s3_hold", cpu_hold, 1);
        chk("s3_no_clr", clr_cnt - c0, 0);

        // scenario 5: restart from ERROR, abort by clr mid-load
        start(5'd4);
        chk("s5_err_cleared", err, 0);
        feed(prog[0], 0);
        feed(prog[1], 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("s5_ready", ld_ready, 0);
        chk("s5_hold", cpu_hold, 1);
        chk("s5_busy", busy, 0);
        load_prog(0);
        check_prog("s5_ram");
        chk("s5_pass_hold", cpu_hold, 0);
        chk("s5_pass_err", err, 0);

        // scenario 6: CPU write then reload; CPU blocked after start
        cpu_addr = 4'h5;
        cpu_wdata = 8'hAA;
        cpu_we = 1'b1;
        step();
        chk("s6_cpu_write", mem[5], 8'hAA);
        ld_len = 5'd4;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        cpu_wdata = 8'h55;
        chk("s6_hold", cpu_hold, 1);
        chk("s6_we_blocked", ram_we, 0);
        step();
        chk("s6_mem5", mem[5], 8'hAA);
        cpu_we = 1'b0;
        for (int i = 0; i < 4; i++) feed(prog[i], 0);
        wait_idle();
        check_prog("s6_ram");
        chk("s6_pass_hold", cpu_hold, 0);
        chk("s6_pass_err", err, 0);

        // scenario 4b: oversize length saturates to 16
        w0 = we_cnt;
        start(5'd20);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!ld_ready) break;
            ld_valid = 1'b1;
            ld_data = 8'(i * 7 + 3);
            step();
            n++;
        end
        ld_valid = 1'b0;
        chk("s4_accepted", n, 16);
        chk("s4_ready_low", ld_ready, 0);
        wait_idle();
        chk("s4_we", we_cnt - w0, 16);
        chk("s4_hold", cpu_hold, 0);
        chk("s4_err", err, 0);
        chk("s4_last_byte", mem[15], 8'(15 * 7 + 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
